// File: rtl/ir_fetch_sequencer.sv
// Instruction fetch/decode sequencer: walks the PC through memory, loads the IR, and hands decoded words to execute.
// Optional macro FETCH_TIMEOUT_EN adds a FETCH wait timeout that sets a sticky fault and halts.
module ir_fetch_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
`ifdef FETCH_TIMEOUT_EN
  , parameter int        TIMEOUT_CYC = 16
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_run,
  input  logic        i_resume,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_ir_load,
  output logic [15:0] o_ir_d,
  input  logic [15:0] i_ir_q,
  output logic        o_exec_valid,
  output logic [3:0]  o_exec_opcode,
  output logic [11:0] o_exec_operand,
  input  logic        i_exec_ack,
  input  logic        i_branch_taken,
  input  logic [15:0] i_branch_target,
  output logic        o_halted,
  output logic        o_fault,
  output logic [15:0] o_instr_count
);

  // state  | meaning
  // IDLE   | waiting for run
  // FETCH  | mem_req held at pc until mem_ack
  // LOAD   | one-cycle IR capture strobe
  // DECODE | ir_q sampled: halt or hand to execute
  // EXEC   | exec_valid held until exec_ack
  // HALT   | parked until resume
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_DECODE, S_EXEC, S_HALT
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, r_ir_d, r_count;
  logic        r_mem_req, r_ir_load, r_exec_valid, r_halted, r_fault;
  logic [3:0]  r_opcode;
  logic [11:0] r_operand;
  logic        w_is_halt;
  logic        w_timeout;

  assign w_is_halt = (i_ir_q[15:12] == HALT_OPCODE);

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_wait;

  // Reloaded whenever outside FETCH, so every FETCH entry starts a fresh window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_wait <= '0;
    else if (r_state != S_FETCH)
      r_wait <= TW'(TIMEOUT_CYC - 1);
    else if (r_wait != '0)
      r_wait <= r_wait - TW'(1);
  end

  assign w_timeout = (r_state == S_FETCH) && !i_mem_ack && (r_wait == '0);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_run) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (i_mem_ack)      w_state_nxt = S_LOAD;
        else if (w_timeout) w_state_nxt = S_HALT;
      end
      S_LOAD:   w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = w_is_halt ? S_HALT : S_EXEC;
      S_EXEC:   if (i_exec_ack) w_state_nxt = i_run ? S_FETCH : S_IDLE;
      S_HALT:   if (i_resume)   w_state_nxt = i_run ? S_FETCH : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc         <= RESET_PC;
      r_ir_d       <= 16'h0000;
      r_count      <= 16'h0000;
      r_mem_req    <= 1'b0;
      r_ir_load    <= 1'b0;
      r_exec_valid <= 1'b0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
      r_opcode     <= 4'h0;
      r_operand    <= 12'h000;
    end else begin
      r_mem_req    <= (w_state_nxt == S_FETCH);
      r_ir_load    <= (w_state_nxt == S_LOAD);
      r_exec_valid <= (w_state_nxt == S_EXEC);
      r_halted     <= (w_state_nxt == S_HALT);
      if (w_timeout)
        r_fault <= 1'b1;
      if (r_state == S_FETCH && i_mem_ack)
        r_ir_d <= i_mem_rdata;
      if (r_state == S_DECODE) begin
        if (w_is_halt) begin
          r_pc    <= r_pc + 16'd1;
          r_count <= r_count + 16'd1;
        end else begin
          r_opcode  <= i_ir_q[15:12];
          r_operand <= i_ir_q[11:0];
        end
      end
      if (r_state == S_EXEC && i_exec_ack) begin
        r_pc    <= i_branch_taken ? i_branch_target : r_pc + 16'd1;
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign o_mem_req      = r_mem_req;
  assign o_mem_addr     = r_pc;
  assign o_ir_load      = r_ir_load;
  assign o_ir_d         = r_ir_d;
  assign o_exec_valid   = r_exec_valid;
  assign o_exec_opcode  = r_opcode;
  assign o_exec_operand = r_operand;
  assign o_halted       = r_halted;
  assign o_fault        = r_fault;
  assign o_instr_count  = r_count;

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Bench for ir_fetch_sequencer: memory/IR/execute responders, a program-level model, and directed checks.
// Build with FETCH_TIMEOUT_EN defined to also exercise the fetch timeout.
`timescale 1ns/1ps
module tb_ir_fetch_sequencer;
  localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef FETCH_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 16;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        run = 1'b0, resume = 1'b0;
  logic        mem_req, mem_ack = 1'b0, ir_load, exec_valid, exec_ack = 1'b0;
  logic [15:0] mem_addr, mem_rdata = 16'h0, ir_d, ir_q = 16'h0, branch_target = 16'h0;
  logic [3:0]  exec_opcode;
  logic [11:0] exec_operand;
  logic        branch_taken = 1'b0, halted, fault;
  logic [15:0] instr_count;

  logic        wr_run = 1'b0, wr_mem_req, wr_mem_ack = 1'b0, wr_ir_load, wr_exec_valid;
  logic        wr_exec_ack = 1'b0, wr_halted, wr_fault;
  logic [15:0] wr_mem_addr, wr_mem_rdata = 16'h0, wr_ir_d, wr_ir_q = 16'h0, wr_instr_count;
  logic [3:0]  wr_opcode;
  logic [11:0] wr_operand;

  ir_fetch_sequencer #(.RESET_PC(RESET_PC)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_resume(resume),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
    .o_ir_load(ir_load), .o_ir_d(ir_d), .i_ir_q(ir_q),
    .o_exec_valid(exec_valid), .o_exec_opcode(exec_opcode), .o_exec_operand(exec_operand),
    .i_exec_ack(exec_ack), .i_branch_taken(branch_taken), .i_branch_target(branch_target),
    .o_halted(halted), .o_fault(fault), .o_instr_count(instr_count));

  ir_fetch_sequencer #(.RESET_PC(16'hFFFF)) u_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(wr_run), .i_resume(1'b0),
    .o_mem_req(wr_mem_req), .o_mem_addr(wr_mem_addr), .i_mem_rdata(wr_mem_rdata), .i_mem_ack(wr_mem_ack),
    .o_ir_load(wr_ir_load), .o_ir_d(wr_ir_d), .i_ir_q(wr_ir_q),
    .o_exec_valid(wr_exec_valid), .o_exec_opcode(wr_opcode), .o_exec_operand(wr_operand),
    .i_exec_ack(wr_exec_ack), .i_branch_taken(1'b0), .i_branch_target(16'h0000),
    .o_halted(wr_halted), .o_fault(wr_fault), .o_instr_count(wr_instr_count));

  // External instruction registers
  always @(posedge clk) if (ir_load) ir_q <= ir_d;
  always @(posedge clk) if (wr_ir_load) wr_ir_q <= wr_ir_d;

  logic [15:0] mem    [0:255];
  logic        br_t   [0:255];
  logic [15:0] br_tgt [0:255];
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'h0000; br_t[i] = 1'b0; br_tgt[i] = 16'h0000;
    end
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'h2ABC; br_t[8'h01] = 1'b1; br_tgt[8'h01] = 16'h00A0;
    mem[8'hA0] = 16'hF000;
    mem[8'hA1] = 16'h3001; br_t[8'hA1] = 1'b1; br_tgt[8'hA1] = 16'hFFFF;
    mem[8'hFF] = 16'h4555;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0, ack_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_ack) ack_cyc <= cyc + 1;
  end

  // Memory responder: answers a request after mem_dly cycles; late_tok forces a stray ack.
  bit mem_en = 1'b1;
  int mem_dly = 2;
  int late_tok = 0, late_seen = 0;
  initial forever begin
    @(negedge clk);
    if (late_tok != late_seen) begin
      late_seen = late_tok;
      mem_rdata = 16'hBEEF; mem_ack = 1'b1;
      @(negedge clk); mem_ack = 1'b0;
    end else if (mem_en && mem_req) begin
      repeat (mem_dly) @(negedge clk);
      if (mem_req) begin
        mem_rdata = mem[mem_addr[7:0]]; mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
      end
    end
  end

  int exec_dly = 1;
  initial forever begin
    @(negedge clk);
    if (exec_valid) begin
      repeat (exec_dly) @(negedge clk);
      exec_ack = 1'b1;
      branch_taken  = br_t[mem_addr[7:0]];
      branch_target = br_tgt[mem_addr[7:0]];
      @(negedge clk);
      exec_ack = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    end
  end

  // Program-level model: pc/count advance on retirement, halt on an F-opcode word.
  logic [15:0] m_pc = RESET_PC, m_count = 16'h0, m_word;
  bit m_halted = 0, m_pend = 0, m_fault = 0;
  int m_wait = 0;
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_pc = RESET_PC; m_count = 16'h0; m_halted = 0; m_pend = 0; m_fault = 0; m_wait = 0;
    end else begin
      m_word = mem[m_pc[7:0]];
      if (m_halted && resume) m_halted = 0;
      if (m_pend) begin
        m_pend = 0; m_pc = m_pc + 16'd1; m_count = m_count + 16'd1; m_halted = 1;
      end else if (ir_load && m_word[15:12] == 4'hF) m_pend = 1;
      if (exec_valid && exec_ack) begin
        m_pc = branch_taken ? branch_target : m_pc + 16'd1;
        m_count = m_count + 16'd1;
      end
`ifdef FETCH_TIMEOUT_EN
      if (mem_req && !mem_ack) begin
        m_wait++;
        if (m_wait == TIMEOUT_CYC) begin m_halted = 1; m_fault = 1; m_wait = 0; end
      end else m_wait = 0;
`endif
    end
    #1;
    chk("instr_count", instr_count, m_count);
    chk("halted", halted, m_halted);
    chk("fault", fault, m_fault);
    if (mem_req)    chk("mem_addr", mem_addr, m_pc);
    if (ir_load)    chk("ir_d", ir_d, mem[m_pc[7:0]]);
    if (exec_valid) chk("exec_fields", {exec_opcode, exec_operand}, mem[m_pc[7:0]]);
    chk("one_phase", ((mem_req + ir_load + exec_valid + halted) <= 1), 1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_sig(input int which, input string name, input int limit);
    bit hit = 0;
    for (int i = 0; i < limit && !hit; i++) begin
      tick(1);
      case (which)
        0: hit = mem_req;
        1: hit = ir_load;
        2: hit = exec_valid;
        3: hit = halted;
        4: hit = !exec_valid;
        5: hit = wr_mem_req;
        default: hit = wr_exec_valid;
      endcase
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL wait_%s: not seen within %0d cycles", name, limit);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tick(2);
    chk("rst_mem_req", mem_req, 0);       chk("rst_ir_load", ir_load, 0);
    chk("rst_exec_valid", exec_valid, 0); chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);           chk("rst_count", instr_count, 0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_ir_d", ir_d, 16'h0000);
    chk("rst_exec_fields", {exec_opcode, exec_operand}, 16'h0000);
    chk("rst_wrap_addr", wr_mem_addr, 16'hFFFF);
    @(negedge clk) rst_n = 1'b1;
    tick(2);
    chk("idle_no_req", mem_req, 0);

    // RESET_PC=FFFF instance: one plain instruction wraps pc to 0
    @(negedge clk) wr_run = 1'b1;
    wait_sig(5, "wr_req", 5);
    chk("wr_addr0", wr_mem_addr, 16'hFFFF);
    @(negedge clk) begin wr_mem_rdata = 16'h5111; wr_mem_ack = 1'b1; end
    @(negedge clk) wr_mem_ack = 1'b0;
    wait_sig(6, "wr_exec", 6);
    chk("wr_fields", {wr_opcode, wr_operand}, 16'h5111);
    @(negedge clk) wr_exec_ack = 1'b1;
    @(negedge clk) wr_exec_ack = 1'b0;
    wait_sig(5, "wr_req2", 5);
    chk("wr_wrap_addr", wr_mem_addr, 16'h0000);
    chk("wr_count", wr_instr_count, 16'h0001);
    wr_run = 1'b0;

    // First instruction, with a stray resume while fetching
    @(negedge clk) run = 1'b1;
    wait_sig(0, "req0", 5);
    chk("addr0", mem_addr, 16'h0000);
    @(negedge clk) resume = 1'b1;
    @(negedge clk) resume = 1'b0;
    wait_sig(1, "load0", 10);
    chk("ir_d0", ir_d, 16'h1234);
    tick(1);
    chk("ir_load_1cyc", ir_load, 0);
    wait_sig(2, "exec0", 5);
    chk("fetch_latency", cyc - ack_cyc + 1, 3);
    chk("opcode0", exec_opcode, 4'h1);
    chk("operand0", exec_operand, 12'h234);
    exec_dly = 0;
    wait_sig(0, "req1", 10);
    chk("addr1", mem_addr, 16'h0001);
    chk("count1", instr_count, 16'h0001);

    // Branch taken, acked in the first EXEC cycle
    wait_sig(2, "exec1", 10);
    chk("fields1", {exec_opcode, exec_operand}, 16'h2ABC);
    tick(1);
    chk("exec_ack_first_cycle", exec_valid, 0);
    wait_sig(0, "reqA0", 10);
    chk("branch_addr", mem_addr, 16'h00A0);
    chk("count2", instr_count, 16'h0002);

    // Halt, run low does not leave HALT, resume fetches pc+1
    wait_sig(3, "halt", 15);
    chk("halt_no_exec", exec_valid, 0);
    chk("halt_count", instr_count, 16'h0003);
    @(negedge clk) run = 1'b0;
    tick(3);
    chk("halt_held", halted, 1);
    @(negedge clk) run = 1'b1;
    tick(2);
    chk("halt_held_run", halted, 1);
    chk("halt_no_req", mem_req, 0);
    @(negedge clk) resume = 1'b1;
    @(negedge clk) resume = 1'b0;
    wait_sig(0, "reqA1", 3);
    chk("resume_addr", mem_addr, 16'h00A1);
    chk("resume_clears_halt", halted, 0);

    // Branch to FFFF, drop run mid-fetch, then pc wraps to 0
    wait_sig(2, "execA1", 10);
    wait_sig(0, "reqFFFF", 10);
    chk("addr_ffff", mem_addr, 16'hFFFF);
    @(negedge clk) run = 1'b0;
    wait_sig(2, "execFFFF", 10);
    chk("fieldsFFFF", {exec_opcode, exec_operand}, 16'h4555);
    wait_sig(4, "execFFFF_done", 10);
    tick(3);
    chk("run_low_idle", mem_req, 0);
    chk("pc_wrap", mem_addr, 16'h0000);
    chk("count5", instr_count, 16'h0005);

    // Reset during FETCH, then a late ack
    @(negedge clk) run = 1'b1;
    wait_sig(2, "exec_again", 15);
    mem_en = 1'b0;
    wait_sig(0, "req_stall", 10);
    chk("stall_addr", mem_addr, 16'h0001);
    tick(2);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", mem_req, 0);
    chk("async_rst_pc", mem_addr, RESET_PC);
    chk("async_rst_count", instr_count, 16'h0000);
    run = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    late_tok++;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("late_ack_no_load", ir_load, 0);
      chk("late_ack_ir_d", ir_d, 16'h0000);
      chk("late_ack_no_req", mem_req, 0);
    end

`ifdef FETCH_TIMEOUT_EN
    begin
      int n;
      @(negedge clk) run = 1'b1;
      wait_sig(0, "req_to", 5);
      n = 1;
      while (mem_req && n < 40) begin
        tick(1);
        if (mem_req) n++;
      end
      chk("timeout_cycles", n, TIMEOUT_CYC);
      chk("timeout_fault", fault, 1);
      chk("timeout_halted", halted, 1);
      chk("timeout_req", mem_req, 0);
      @(negedge clk) resume = 1'b1;
      @(negedge clk) resume = 1'b0;
      wait_sig(0, "req_retry", 3);
      chk("retry_addr", mem_addr, 16'h0000);
      chk("fault_sticky", fault, 1);
    end
`endif

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ir_fetch_sequencer.md
Name: ir_fetch_sequencer

Overview:
Fetch/decode sequencer for the 16-bit CPU's instruction register. It holds the program counter and issues instruction reads to memory through a req/ack handshake. It drives the load strobe and data into the IR, then decodes the IR opcode and hands each instruction to the execute stage. It sits between the memory interface, the IR and the execute datapath.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
HALT_OPCODE, 4'hF, opcode (ir_q[15:12]) that halts the sequencer
TIMEOUT_CYC, 16, max FETCH wait cycles for mem_ack (used only with FETCH_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
run  input  1  level; 1 permits fetching
resume  input  1  one-cycle pulse; leaves HALT
mem_req  output  1  instruction read request
mem_addr  output  16  read address (= pc)
mem_rdata  input  16  read data, valid when mem_ack=1
mem_ack  input  1  read completion, one-cycle pulse
ir_load  output  1  IR capture strobe
ir_d  output  16  data presented to IR d input
ir_q  input  16  IR q output
exec_valid  output  1  instruction available to execute stage
exec_opcode  output  4  ir_q[15:12], registered in DECODE
exec_operand  output  12  ir_q[11:0], registered in DECODE
exec_ack  input  1  execute stage done
branch_taken  input  1  sampled with exec_ack
branch_target  input  16  sampled with exec_ack
halted  output  1  1 in HALT state
fault  output  1  sticky fetch timeout flag
instr_count  output  16  retired instruction counter

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, ir_d=0, instr_count=0. All of these outputs are 0: mem_req, ir_load, exec_valid, exec_opcode, exec_operand, halted, fault.
- Reset mid-operation aborts any outstanding request. A mem_ack arriving after reset is ignored.
- States: IDLE, FETCH, LOAD, DECODE, EXEC, HALT. All outputs are registered.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH: mem_req=1, mem_addr=pc, both held stable until mem_ack.
  - On mem_ack: ir_d<=mem_rdata, go to LOAD.
  - mem_ack outside FETCH is ignored.
- LOAD: ir_load=1 for exactly one cycle, with ir_d stable. The IR captures at the edge ending LOAD. Next state is DECODE.
- DECODE: sample ir_q.
  - If ir_q[15:12]==HALT_OPCODE: go to HALT. pc<=pc+1. instr_count increments.
  - Otherwise: register exec_opcode and exec_operand, go to EXEC.
- EXEC: exec_valid=1 until exec_ack. The exec_ack cycle itself may be the first EXEC cycle.
  - On exec_ack: exec_valid<=0. instr_count<=instr_count+1.
  - pc<=branch_target if branch_taken, else pc+1.
  - Next state is FETCH if run=1, else IDLE.
- Fetch latency: mem_ack cycle to exec_valid high is 3 edges (LOAD, DECODE, EXEC).
- HALT: halted=1. resume=1 goes to FETCH if run=1, else IDLE; halted clears on the same edge. A run deassertion alone does not leave HALT.
- Wrap-around: pc and instr_count are modulo 2^16 (16'hFFFF+1=16'h0000), with no flag.
- run deasserted mid-fetch: the current instruction completes through EXEC, then the sequencer goes to IDLE.
- Simultaneous events:
  - exec_ack with branch_taken: branch_target wins over increment.
  - resume outside HALT: ignored.

Optional Feature:
Macro: FETCH_TIMEOUT_EN.
- Defined: a wait counter runs in FETCH, cleared on entry.
  - If TIMEOUT_CYC cycles elapse without mem_ack: mem_req<=0, fault<=1 (sticky until reset), state<=HALT, pc unchanged.
  - resume then retries the same pc.
- Not defined: FETCH waits indefinitely and fault is tied to 0.

Test Plan:
- Reset, run=1, mem_ack after 2 cycles with rdata=16'h1234 -> mem_addr=0; ir_load for 1 cycle with ir_d=16'h1234; exec_opcode=4'h1, exec_operand=12'h234; after exec_ack, pc=1 and instr_count=1.
- Branch: exec_ack with branch_taken=1, branch_target=16'h00A0 -> next mem_addr=16'h00A0.
- Halt: rdata=16'hF000 -> halted=1, no exec_valid, pc+1; resume pulse -> mem_req at pc+1.
- Wrap: RESET_PC=16'hFFFF, one non-branch instruction -> next mem_addr=16'h0000.
- Reset asserted during FETCH with mem_req=1 -> mem_req=0 immediately (async), pc=RESET_PC, late mem_ack ignored.
- FETCH_TIMEOUT_EN, TIMEOUT_CYC=16, no ack -> after 16 cycles fault=1, halted=1, mem_req=0; resume -> same mem_addr re-requested.
